// File: rtl/issue_ctrl.sv
// Single-entry in-order issue controller: holds one decoded instruction, checks
// it against a register scoreboard, and stalls behind unresolved branches/jumps.
module issue_ctrl #(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        uses_rs1_i,
  input  logic        uses_rs2_i,
  input  logic        reg_write_en_i,
  input  logic        branch_i,
  input  logic        jump_i,
  output logic        issue_valid_o,
  input  logic        issue_ready_i,
  output logic [4:0]  issue_rd_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        resolve_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic {RUN, BRWAIT} state_t;

  state_t              state, state_next;
  logic                buf_valid;
  logic [4:0]          buf_rs1, buf_rs2, buf_rd;
  logic                buf_uses_rs1, buf_uses_rs2, buf_we, buf_branch, buf_jump;
  logic [NUM_REGS-1:0] sb, sb_next;
  logic                hazard, fire, capture, stall;

  // x0 never hazards: the lookup skips entry 0 entirely.
  function automatic logic sb_hit(input logic [NUM_REGS-1:0] v, input logic [4:0] addr);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 1; i < NUM_REGS; i++)
      if (32'(addr) == i) hit = v[i];
    return hit;
  endfunction

  always_comb begin
    hazard = (buf_uses_rs1 && sb_hit(sb, buf_rs1)) |
             (buf_uses_rs2 && sb_hit(sb, buf_rs2)) |
             (buf_we       && sb_hit(sb, buf_rd));
  end

  // Reset also gates issue so nothing escapes during the reset cycle.
  always_comb begin
    state_next    = state;
    issue_valid_o = 1'b0;
    in_ready_o    = 1'b0;
    fire          = 1'b0;
    capture       = 1'b0;
    stall         = 1'b0;
    if (rst_n && !flush_i && state == RUN) begin
      issue_valid_o = buf_valid && !hazard;
      fire          = issue_valid_o && issue_ready_i;
      in_ready_o    = !buf_valid || fire;
      capture       = in_valid_i && in_ready_o;
      stall         = buf_valid && hazard;
    end
    if (flush_i)
      state_next = RUN;
    else if (state == RUN && fire && (buf_branch || buf_jump))
      state_next = BRWAIT;
    else if (state == BRWAIT && resolve_i)
      state_next = RUN;
  end

  // Set is applied after clear so a same-register collision leaves the bit set.
  always_comb begin
    sb_next = sb;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (wb_valid_i && 32'(wb_rd_i) == i) sb_next[i] = 1'b0;
      if (fire && buf_we && 32'(buf_rd) == i) sb_next[i] = 1'b1;
    end
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      buf_valid   <= 1'b0;
      sb          <= '0;
      stall_cnt_o <= '0;
    end else begin
      state <= state_next;
      sb    <= sb_next;
      if (flush_i)
        buf_valid <= 1'b0;
      else if (capture)
        buf_valid <= 1'b1;
      else if (fire)
        buf_valid <= 1'b0;
      if (stall && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      buf_rs1      <= rs1_addr_i;
      buf_rs2      <= rs2_addr_i;
      buf_rd       <= rd_addr_i;
      buf_uses_rs1 <= uses_rs1_i;
      buf_uses_rs2 <= uses_rs2_i;
      buf_we       <= reg_write_en_i;
      buf_branch   <= branch_i;
      buf_jump     <= jump_i;
    end
  end

  assign busy_o     = |sb;
  assign issue_rd_o = buf_rd;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed self-checking bench for issue_ctrl: inputs change on the falling edge,
// outputs are checked 1ns later.
module tb_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i, in_ready_o;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic        uses_rs1_i, uses_rs2_i, reg_write_en_i, branch_i, jump_i;
  logic        issue_valid_o, issue_ready_i;
  logic [4:0]  issue_rd_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        resolve_i, flush_i, busy_o;
  logic [15:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  issue_ctrl #(.NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .uses_rs1_i(uses_rs1_i), .uses_rs2_i(uses_rs2_i), .reg_write_en_i(reg_write_en_i),
    .branch_i(branch_i), .jump_i(jump_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i), .issue_rd_o(issue_rd_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
    .resolve_i(resolve_i), .flush_i(flush_i),
    .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    in_valid_i = 0; rs1_addr_i = 0; rs2_addr_i = 0; rd_addr_i = 0;
    uses_rs1_i = 0; uses_rs2_i = 0; reg_write_en_i = 0; branch_i = 0; jump_i = 0;
    issue_ready_i = 1; wb_valid_i = 0; wb_rd_i = 0; resolve_i = 0; flush_i = 0;
  endtask

  task automatic present(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic we,
                         input logic br, input logic jp);
    in_valid_i = 1; rd_addr_i = rd; rs1_addr_i = rs1; rs2_addr_i = rs2;
    uses_rs1_i = u1; uses_rs2_i = u2; reg_write_en_i = we; branch_i = br; jump_i = jp;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    present(3, 1, 2, 1, 1, 1, 0, 0);
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL rst_in_ready_low: got %b expected 0", in_ready_o); end
    checks++; if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL rst_issue_valid: got %b expected 0", issue_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
    checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d expected 0", stall_cnt_o); end
    rst_n = 1; in_valid_i = 0; #1;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", in_ready_o); end
    checks++; if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL rst_release_iv: got %b expected 0", issue_valid_o); end
  endtask

  task automatic test_basic();
    do_reset();
    present(3, 1, 2, 1, 1, 1, 0, 0);
    @(negedge clk); in_valid_i = 0; #1;
    checks++; if (issue_valid_o !== 1'b1) begin errors++; $display("FAIL basic_iv: got %b expected 1", issue_valid_o); end
    checks++; if (issue_rd_o !== 5'd3) begin errors++; $display("FAIL basic_rd: got %0d expected 3", issue_rd_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy_pre: got %b expected 0", busy_o); end
    @(negedge clk); #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy_o); end
    checks++; if (dut.sb !== 32'h0000_0008) begin errors++; $display("FAIL basic_sb: got %h expected 00000008", dut.sb); end
    checks++; if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL basic_iv_after: got %b expected 0", issue_valid_o); end
    wb_valid_i = 1; wb_rd_i = 3;
    @(negedge clk); wb_valid_i = 0; #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_wb_clear: got %b expected 0", busy_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    present(10, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk); present(11, 0, 0, 0, 0, 1, 0, 0); #1;
    checks++; if (issue_valid_o !== 1'b1 || issue_rd_o !== 5'd10) begin errors++; $display("FAIL b2b_first: got iv=%b rd=%0d expected iv=1 rd=10", issue_valid_o, issue_rd_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", in_ready_o); end
    @(negedge clk); present(12, 0, 0, 0, 0, 1, 0, 0); #1;
    checks++; if (issue_valid_o !== 1'b1 || issue_rd_o !== 5'd11) begin errors++; $display("FAIL b2b_second: got iv=%b rd=%0d expected iv=1 rd=11", issue_valid_o, issue_rd_o); end
    @(negedge clk); in_valid_i = 0; #1;
    checks++; if (issue_valid_o !== 1'b1 || issue_rd_o !== 5'd12) begin errors++; $display("FAIL b2b_third: got iv=%b rd=%0d expected iv=1 rd=12", issue_valid_o, issue_rd_o); end
    @(negedge clk); #1;
    checks++; if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", issue_valid_o); end
    checks++; if (dut.sb !== 32'h0000_1C00) begin errors++; $display("FAIL b2b_sb: got %h expected 00001c00", dut.sb); end
  endtask

  task automatic test_raw();
    do_reset();
    present(3, 1, 2, 1, 1, 1, 0, 0);
    @(negedge clk); present(4, 3, 0, 1, 0, 1, 0, 0); #1;
    checks++; if (issue_valid_o !== 1'b1) begin errors++; $display("FAIL raw_producer: got %b expected 1", issue_valid_o); end
    @(negedge clk); in_valid_i = 0; #1;
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL raw_ready_stall: got %b expected 0", in_ready_o); end
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 4) begin wb_valid_i = 1; wb_rd_i = 3; end
      #1;
      checks++; if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL raw_stall_c%0d: got %b expected 0", c, issue_valid_o); end
    end
    @(negedge clk); wb_valid_i = 0; #1;
    checks++; if (issue_valid_o !== 1'b1 || issue_rd_o !== 5'd4) begin errors++; $display("FAIL raw_release: got iv=%b rd=%0d expected iv=1 rd=4", issue_valid_o, issue_rd_o); end
    checks++; if (stall_cnt_o !== 16'd4) begin errors++; $display("FAIL raw_stall_cnt: got %0d expected 4", stall_cnt_o); end
    @(negedge clk); #1;
    checks++; if (dut.sb !== 32'h0000_0010) begin errors++; $display("FAIL raw_sb: got %h expected 00000010", dut.sb); end
  endtask

  task automatic test_x0();
    do_reset();
    present(0, 1, 2, 1, 1, 1, 0, 0);
    @(negedge clk); present(5, 0, 0, 1, 1, 1, 0, 0); #1;
    checks++; if (issue_valid_o !== 1'b1 || issue_rd_o !== 5'd0) begin errors++; $display("FAIL x0_write_iv: got iv=%b rd=%0d expected iv=1 rd=0", issue_valid_o, issue_rd_o); end
    @(negedge clk); in_valid_i = 0; #1;
    checks++; if (dut.sb !== 32'h0) begin errors++; $display("FAIL x0_sb: got %h expected 00000000", dut.sb); end
    checks++; if (issue_valid_o !== 1'b1 || issue_rd_o !== 5'd5) begin errors++; $display("FAIL x0_read_iv: got iv=%b rd=%0d expected iv=1 rd=5", issue_valid_o, issue_rd_o); end
    checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL x0_stall: got %0d expected 0", stall_cnt_o); end
    @(negedge clk); #1;
    checks++; if (dut.sb !== 32'h0000_0020) begin errors++; $display("FAIL x0_sb_after: got %h expected 00000020", dut.sb); end
  endtask

  task automatic test_branch();
    do_reset();
    present(0, 1, 2, 1, 1, 0, 1, 0);
    @(negedge clk); present(6, 0, 0, 0, 0, 1, 0, 0); #1;
    checks++; if (issue_valid_o !== 1'b1 || in_ready_o !== 1'b1) begin errors++; $display("FAIL br_issue: got iv=%b rdy=%b expected 1 1", issue_valid_o, in_ready_o); end
    @(negedge clk); in_valid_i = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 3) resolve_i = 1;
      #1;
      checks++; if (in_ready_o !== 1'b0 || issue_valid_o !== 1'b0) begin errors++; $display("FAIL br_wait_c%0d: got rdy=%b iv=%b expected 0 0", c, in_ready_o, issue_valid_o); end
    end
    @(negedge clk); resolve_i = 0; #1;
    checks++; if (issue_valid_o !== 1'b1 || issue_rd_o !== 5'd6 || in_ready_o !== 1'b1) begin errors++; $display("FAIL br_resume: got iv=%b rd=%0d rdy=%b expected 1 6 1", issue_valid_o, issue_rd_o, in_ready_o); end
    @(negedge clk); #1;
    checks++; if (dut.sb !== 32'h0000_0040) begin errors++; $display("FAIL br_sb: got %h expected 00000040", dut.sb); end
  endtask

  task automatic test_flush();
    do_reset();
    present(3, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk); present(8, 3, 0, 1, 0, 1, 0, 0); #1;
    checks++; if (issue_valid_o !== 1'b1) begin errors++; $display("FAIL fl_producer: got %b expected 1", issue_valid_o); end
    @(negedge clk); flush_i = 1; present(7, 0, 0, 0, 0, 1, 0, 0); #1;
    checks++; if (issue_valid_o !== 1'b0 || in_ready_o !== 1'b0) begin errors++; $display("FAIL fl_during: got iv=%b rdy=%b expected 0 0", issue_valid_o, in_ready_o); end
    @(negedge clk); flush_i = 0; in_valid_i = 0; #1;
    checks++; if (dut.buf_valid !== 1'b0) begin errors++; $display("FAIL fl_buf_empty: got %b expected 0", dut.buf_valid); end
    checks++; if (dut.sb !== 32'h0000_0008) begin errors++; $display("FAIL fl_sb: got %h expected 00000008", dut.sb); end
    checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL fl_stall: got %0d expected 0", stall_cnt_o); end
    checks++; if (in_ready_o !== 1'b1 || issue_valid_o !== 1'b0) begin errors++; $display("FAIL fl_after: got rdy=%b iv=%b expected 1 0", in_ready_o, issue_valid_o); end
    present(1, 0, 0, 0, 0, 1, 0, 1);
    @(negedge clk); in_valid_i = 0; #1;
    checks++; if (issue_valid_o !== 1'b1) begin errors++; $display("FAIL jmp_issue: got %b expected 1", issue_valid_o); end
    @(negedge clk); #1;
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL jmp_wait: got %b expected 0", in_ready_o); end
    flush_i = 1;
    @(negedge clk); flush_i = 0; #1;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL jmp_flush_run: got %b expected 1", in_ready_o); end
    checks++; if (dut.sb !== 32'h0000_000A) begin errors++; $display("FAIL jmp_sb: got %h expected 0000000a", dut.sb); end
  endtask

  task automatic test_setclr_sat();
    do_reset();
    present(5, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk); in_valid_i = 0; wb_valid_i = 1; wb_rd_i = 5; #1;
    checks++; if (issue_valid_o !== 1'b1) begin errors++; $display("FAIL sc_fire: got %b expected 1", issue_valid_o); end
    @(negedge clk); wb_rd_i = 9; #1;
    checks++; if (dut.sb !== 32'h0000_0020) begin errors++; $display("FAIL sc_set_wins: got %h expected 00000020", dut.sb); end
    @(negedge clk); wb_valid_i = 0; #1;
    checks++; if (dut.sb !== 32'h0000_0020) begin errors++; $display("FAIL sc_clear_noop: got %h expected 00000020", dut.sb); end
    present(6, 5, 0, 1, 0, 1, 0, 0);
    @(negedge clk); in_valid_i = 0;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (stall_cnt_o !== 16'd10) begin errors++; $display("FAIL sat_cnt10: got %0d expected 10", stall_cnt_o); end
    repeat (65524) @(negedge clk);
    #1;
    checks++; if (stall_cnt_o !== 16'hFFFE) begin errors++; $display("FAIL sat_cnt_fffe: got %h expected fffe", stall_cnt_o); end
    repeat (6) @(negedge clk);
    #1;
    checks++; if (stall_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt_ffff: got %h expected ffff", stall_cnt_o); end
    wb_valid_i = 1; wb_rd_i = 5;
    @(negedge clk); wb_valid_i = 0; rst_n = 0; #1;
    checks++; if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_no_issue: got %b expected 0", issue_valid_o); end
    @(negedge clk); #1;
    checks++; if (busy_o !== 1'b0 || stall_cnt_o !== 16'd0 || in_ready_o !== 1'b0) begin errors++; $display("FAIL midrst_state: got busy=%b cnt=%0d rdy=%b expected 0 0 0", busy_o, stall_cnt_o, in_ready_o); end
    rst_n = 1; #1;
    checks++; if (in_ready_o !== 1'b1 || issue_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_release: got rdy=%b iv=%b expected 1 0", in_ready_o, issue_valid_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_raw();
    test_x0();
    test_branch();
    test_flush();
    test_setclr_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
